// File: rtl/serial_word_rx.sv
// LSB-first serial-to-parallel receiver with a valid/ready word output.
// Optional sticky overrun flag enabled by defining SERIAL_RX_OVERRUN_EN.
module serial_word_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e            state;
  logic [WIDTH-1:0]  sreg;
  logic [CntW-1:0]   cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      sreg       <= '0;
      cnt        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bit_valid && sof) begin
            sreg[WIDTH-1] <= bit_in;
            cnt           <= CntW'(1);
            state         <= StShift;
          end
        end
        StShift: begin
          if (bit_valid) begin
            if (sof) begin
              // Abort the partial word; this bit becomes bit 0 of a new one.
              sreg[WIDTH-1] <= bit_in;
              cnt           <= CntW'(1);
              frame_err     <= 1'b1;
            end else if (cnt == CntW'(WIDTH - 1)) begin
              sreg       <= {bit_in, sreg[WIDTH-1:1]};
              word_out   <= {bit_in, sreg[WIDTH-1:1]};
              word_valid <= 1'b1;
              cnt        <= '0;
              state      <= StHold;
            end else begin
              sreg <= {bit_in, sreg[WIDTH-1:1]};
              cnt  <= cnt + 1'b1;
            end
          end
        end
        StHold: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (bit_valid && sof) begin
              sreg[WIDTH-1] <= bit_in;
              cnt           <= CntW'(1);
              state         <= StShift;
            end else begin
              state <= StIdle;
            end
          end
`ifdef SERIAL_RX_OVERRUN_EN
          // Any bit not taken as a new frame start is lost while holding.
          if (bit_valid && !(word_ready && sof)) begin
            overrun <= 1'b1;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
